// File: rtl/ctrl_pipe_if.sv
// LC-3b control types plus the handshake bundle between decode, the control
// pipe and the memory stage.
package lc3b_pkg;

  typedef enum logic [3:0] {
    op_br  = 4'd0,  op_add = 4'd1,  op_ldb = 4'd2,  op_stb  = 4'd3,
    op_jsr = 4'd4,  op_and = 4'd5,  op_ldr = 4'd6,  op_str  = 4'd7,
    op_rti = 4'd8,  op_not = 4'd9,  op_ldi = 4'd10, op_sti  = 4'd11,
    op_jmp = 4'd12, op_shf = 4'd13, op_lea = 4'd14, op_trap = 4'd15
  } lc3b_opcode;

  typedef enum logic [2:0] {
    alu_add  = 3'd0, alu_and = 3'd1, alu_not = 3'd2, alu_pass = 3'd3,
    alu_sll  = 3'd4, alu_srl = 3'd5, alu_sra = 3'd6
  } lc3b_aluop;

  typedef struct packed {
    logic [3:0] opcode;
    lc3b_aluop  aluop;
    logic       b1_mux_sel;
    logic       reg_load;
    logic       load_cc;
    logic       mem_read;
    logic       mem_write;
    logic       mem_byte;
    logic       ldi_sti;
    logic       br;
    logic       jmp;
    logic       jsr;
    logic       jsr_imm;
    logic       trap;
  } lc3b_control_word;

endpackage

interface ctrl_pipe_if #(
  parameter int NSTAGE = 3,
  parameter int CW_W   = $bits(lc3b_pkg::lc3b_control_word)
);
  logic                   if_valid;
  logic [3:0]             opcode;
  logic                   bit11;
  logic                   bit5;
  logic                   bit4;
  logic                   id_ready;
  logic                   flush;
  logic                   mem_resp;
  logic                   mem_phase;
  logic [NSTAGE-1:0]      stage_valid;
  logic [NSTAGE*CW_W-1:0] stage_ctrl;
  logic                   illegal;

  modport master (
    output if_valid, opcode, bit11, bit5, bit4, flush, mem_resp,
    input  id_ready, mem_phase, stage_valid, stage_ctrl, illegal
  );

  modport slave (
    input  if_valid, opcode, bit11, bit5, bit4, flush, mem_resp,
    output id_ready, mem_phase, stage_valid, stage_ctrl, illegal
  );
endinterface

// File: rtl/ctrl_pipe.sv
// LC-3b control pipe: decodes the ID opcode into a control word and carries it
// through NSTAGE registered stages, holding the front end during memory access.
module ctrl_pipe
  import lc3b_pkg::*;
#(
  parameter int NSTAGE          = 3,
  parameter int MEM_IDX         = 1,
  parameter int CW_W            = $bits(lc3b_control_word),
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic      clk,
  input  logic      reset_n,
  ctrl_pipe_if.slave bus
);

  if (NSTAGE < 3 || MEM_IDX < 1 || MEM_IDX >= NSTAGE - 1 ||
      CW_W != $bits(lc3b_control_word)) begin : g_bad_params
    $error("ctrl_pipe: illegal NSTAGE/MEM_IDX/CW_W combination");
  end

  lc3b_control_word r_ctrl [NSTAGE];
  logic             r_valid [NSTAGE];
  logic             r_mem_cnt;
  logic             r_illegal;

  lc3b_control_word w_dec;
  logic             w_illegal_op;
  logic             w_id_valid;
  lc3b_opcode       w_mem_op;
  logic             w_memop;
  logic [1:0]       w_need;
  logic             w_done;
  logic             w_hold;
  logic             w_capture;
  lc3b_control_word w_in_ctrl [NSTAGE];
  logic             w_in_valid [NSTAGE];

  always_comb begin
    w_dec        = '0;
    w_illegal_op = 1'b0;
    w_dec.opcode = bus.opcode;
    case (lc3b_opcode'(bus.opcode))
      op_add: begin
        w_dec.aluop      = alu_add;
        w_dec.b1_mux_sel = bus.bit5;
        w_dec.reg_load   = 1'b1;
        w_dec.load_cc    = 1'b1;
      end
      op_and: begin
        w_dec.aluop      = alu_and;
        w_dec.b1_mux_sel = bus.bit5;
        w_dec.reg_load   = 1'b1;
        w_dec.load_cc    = 1'b1;
      end
      op_not: begin
        w_dec.aluop    = alu_not;
        w_dec.reg_load = 1'b1;
        w_dec.load_cc  = 1'b1;
      end
      op_shf: begin
        if (!bus.bit4)     w_dec.aluop = alu_sll;
        else if (!bus.bit5) w_dec.aluop = alu_srl;
        else               w_dec.aluop = alu_sra;
        w_dec.reg_load = 1'b1;
        w_dec.load_cc  = 1'b1;
      end
      op_lea: begin
        w_dec.aluop    = alu_pass;
        w_dec.reg_load = 1'b1;
      end
      op_ldb: begin
        w_dec.mem_read = 1'b1;
        w_dec.mem_byte = 1'b1;
        w_dec.reg_load = 1'b1;
        w_dec.load_cc  = 1'b1;
      end
      op_ldr: begin
        w_dec.mem_read = 1'b1;
        w_dec.reg_load = 1'b1;
        w_dec.load_cc  = 1'b1;
      end
      op_ldi: begin
        w_dec.mem_read = 1'b1;
        w_dec.ldi_sti  = 1'b1;
        w_dec.reg_load = 1'b1;
        w_dec.load_cc  = 1'b1;
      end
      op_stb: begin
        w_dec.mem_write = 1'b1;
        w_dec.mem_byte  = 1'b1;
      end
      op_str:  w_dec.mem_write = 1'b1;
      op_sti: begin
        w_dec.mem_write = 1'b1;
        w_dec.ldi_sti   = 1'b1;
      end
      op_br:   w_dec.br = 1'b1;
      op_jmp:  w_dec.jmp = 1'b1;
      op_jsr: begin
        w_dec.jsr      = 1'b1;
        w_dec.jsr_imm  = bus.bit11;
        w_dec.reg_load = 1'b1;
      end
      op_trap: begin
        w_dec.trap     = 1'b1;
        w_dec.reg_load = 1'b1;
      end
      default: begin
        w_dec        = '0;
        w_illegal_op = 1'b1;
      end
    endcase
  end

  assign w_id_valid = bus.if_valid && !(w_illegal_op && TRAP_ON_ILLEGAL);

  // Memory-stage access tracking; mem_resp only ever reaches id_ready
  // combinationally, never the stage registers' outputs.
  assign w_mem_op = lc3b_opcode'(r_ctrl[MEM_IDX].opcode);
  assign w_memop  = r_valid[MEM_IDX] &&
                    (w_mem_op inside {op_ldb, op_ldr, op_ldi, op_stb, op_str, op_sti});
  assign w_need   = r_ctrl[MEM_IDX].ldi_sti ? 2'd2 : 2'd1;
  assign w_done   = bus.mem_resp && (({1'b0, r_mem_cnt} + 2'd1) == w_need);
  assign w_hold   = w_memop && !w_done;
  assign w_capture = bus.if_valid && !w_hold && !bus.flush;

  assign bus.id_ready  = !w_hold;
  assign bus.mem_phase = r_mem_cnt;
  assign bus.illegal   = r_illegal;

  for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign w_in_ctrl[gi]  = w_dec;
      assign w_in_valid[gi] = w_id_valid;
    end else begin : g_body
      assign w_in_ctrl[gi]  = r_ctrl[gi-1];
      assign w_in_valid[gi] = r_valid[gi-1];
    end
    assign bus.stage_valid[gi]             = r_valid[gi];
    assign bus.stage_ctrl[gi*CW_W +: CW_W] = r_ctrl[gi];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSTAGE; i++) begin
        r_valid[i] <= 1'b0;
        r_ctrl[i]  <= '0;
      end
      r_mem_cnt <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (i == MEM_IDX + 1 && w_hold) begin
          r_valid[i] <= 1'b0;
          r_ctrl[i]  <= '0;
        end else if (i > MEM_IDX) begin
          r_valid[i] <= w_in_valid[i];
          r_ctrl[i]  <= w_in_ctrl[i];
        end else if (i < MEM_IDX && bus.flush) begin
          r_valid[i] <= 1'b0;
          r_ctrl[i]  <= '0;
        end else if (!w_hold) begin
          r_valid[i] <= w_in_valid[i];
          r_ctrl[i]  <= w_in_ctrl[i];
        end
      end
      if (w_hold && bus.mem_resp) r_mem_cnt <= 1'b1;
      else if (!w_hold)           r_mem_cnt <= 1'b0;
      r_illegal <= w_capture && w_illegal_op;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: a queue-based pipeline model checked every cycle against
// two instances (trap on / trap off), plus hand-computed control words.
module tb_ctrl_pipe;
  import lc3b_pkg::*;

  localparam int NS = 3;
  localparam int MI = 1;
  localparam int CW = $bits(lc3b_control_word);

  localparam logic [CW-1:0] W_ADD_I = 19'h08E00;
  localparam logic [CW-1:0] W_ADD_R = 19'h08600;
  localparam logic [CW-1:0] W_LDR   = 19'h30700;
  localparam logic [CW-1:0] W_LDI   = 19'h50720;
  localparam logic [CW-1:0] W_SRA   = 19'h6E600;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_valid = 1'b0;
  logic [3:0] s_op = 4'd0;
  logic       s_b11 = 1'b0, s_b5 = 1'b0, s_b4 = 1'b0, s_flush = 1'b0, s_resp = 1'b0;

  ctrl_pipe_if #(.NSTAGE(NS), .CW_W(CW)) bus_a ();
  ctrl_pipe_if #(.NSTAGE(NS), .CW_W(CW)) bus_b ();

  assign bus_a.if_valid = s_valid;  assign bus_b.if_valid = s_valid;
  assign bus_a.opcode   = s_op;     assign bus_b.opcode   = s_op;
  assign bus_a.bit11    = s_b11;    assign bus_b.bit11    = s_b11;
  assign bus_a.bit5     = s_b5;     assign bus_b.bit5     = s_b5;
  assign bus_a.bit4     = s_b4;     assign bus_b.bit4     = s_b4;
  assign bus_a.flush    = s_flush;  assign bus_b.flush    = s_flush;
  assign bus_a.mem_resp = s_resp;   assign bus_b.mem_resp = s_resp;

  ctrl_pipe #(.NSTAGE(NS), .MEM_IDX(MI), .CW_W(CW), .TRAP_ON_ILLEGAL(1'b1)) u_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a));
  ctrl_pipe #(.NSTAGE(NS), .MEM_IDX(MI), .CW_W(CW), .TRAP_ON_ILLEGAL(1'b0)) u_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model ----------------
  typedef struct {
    bit               v;
    lc3b_control_word w;
  } ent_t;

  ent_t m_pipe [2][NS];
  bit   m_cnt [2];
  bit   m_ill [2];

  function automatic lc3b_control_word exp_word(bit [3:0] op, bit b11, bit b5, bit b4);
    lc3b_control_word w;
    w = '0;
    w.opcode = op;
    case (lc3b_opcode'(op))
      op_add:  begin w.aluop = alu_add; w.b1_mux_sel = b5; w.reg_load = 1; w.load_cc = 1; end
      op_and:  begin w.aluop = alu_and; w.b1_mux_sel = b5; w.reg_load = 1; w.load_cc = 1; end
      op_not:  begin w.aluop = alu_not; w.reg_load = 1; w.load_cc = 1; end
      op_shf:  begin
        w.aluop = !b4 ? alu_sll : (b5 ? alu_sra : alu_srl);
        w.reg_load = 1; w.load_cc = 1;
      end
      op_lea:  begin w.aluop = alu_pass; w.reg_load = 1; end
      op_ldb:  begin w.mem_read = 1; w.mem_byte = 1; w.reg_load = 1; w.load_cc = 1; end
      op_ldr:  begin w.mem_read = 1; w.reg_load = 1; w.load_cc = 1; end
      op_ldi:  begin w.mem_read = 1; w.ldi_sti = 1; w.reg_load = 1; w.load_cc = 1; end
      op_stb:  begin w.mem_write = 1; w.mem_byte = 1; end
      op_str:  w.mem_write = 1;
      op_sti:  begin w.mem_write = 1; w.ldi_sti = 1; end
      op_br:   w.br = 1;
      op_jmp:  w.jmp = 1;
      op_jsr:  begin w.jsr = 1; w.jsr_imm = b11; w.reg_load = 1; end
      op_trap: begin w.trap = 1; w.reg_load = 1; end
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic bit is_mem(ent_t e);
    return e.v && (e.w.opcode inside {4'd2, 4'd3, 4'd6, 4'd7, 4'd10, 4'd11});
  endfunction

  function automatic bit m_hold(int k);
    int need;
    need = m_pipe[k][MI].w.ldi_sti ? 2 : 1;
    return is_mem(m_pipe[k][MI]) && !(s_resp && (int'(m_cnt[k]) + 1 == need));
  endfunction

  task automatic m_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NS; i++) begin
        m_pipe[k][i].v = 1'b0;
        m_pipe[k][i].w = '0;
      end
      m_cnt[k] = 1'b0;
      m_ill[k] = 1'b0;
    end
  endtask

  task automatic m_step(int k);
    ent_t q[$];
    ent_t bub, id;
    bit   h, ill_op;
    h = m_hold(k);
    ill_op = (s_op == 4'd8);
    bub.v = 1'b0;
    bub.w = '0;
    id.w = exp_word(s_op, s_b11, s_b5, s_b4);
    id.v = s_valid && !(ill_op && k == 0);
    for (int i = 0; i < NS; i++) q.push_back(m_pipe[k][i]);
    if (!h) q.push_front(id);
    else    q.insert(MI + 1, bub);
    void'(q.pop_back());
    if (s_flush) for (int i = 0; i < MI; i++) q[i] = bub;
    if (h && s_resp) m_cnt[k] = 1'b1;
    else if (!h)     m_cnt[k] = 1'b0;
    m_ill[k] = s_valid && !h && !s_flush && ill_op;
    for (int i = 0; i < NS; i++) m_pipe[k][i] = q[i];
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_clear();
    else begin
      m_step(0);
      m_step(1);
    end
  end

  function automatic logic [NS-1:0] exp_valid(int k);
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = m_pipe[k][i].v;
    return v;
  endfunction

  function automatic logic [NS*CW-1:0] exp_ctrl(int k);
    logic [NS*CW-1:0] c;
    for (int i = 0; i < NS; i++) c[i*CW +: CW] = m_pipe[k][i].w;
    return c;
  endfunction

  function automatic logic [CW-1:0] a_ctrl(int i);
    return bus_a.stage_ctrl[i*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] b_ctrl(int i);
    return bus_b.stage_ctrl[i*CW +: CW];
  endfunction

  bit run_cmp = 1'b0;

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("a_valid",    bus_a.stage_valid, exp_valid(0));
      chk("a_ctrl",     bus_a.stage_ctrl,  exp_ctrl(0));
      chk("a_illegal",  bus_a.illegal,     m_ill[0]);
      chk("a_phase",    bus_a.mem_phase,   m_cnt[0]);
      chk("a_id_ready", bus_a.id_ready,    !m_hold(0));
      chk("b_valid",    bus_b.stage_valid, exp_valid(1));
      chk("b_ctrl",     bus_b.stage_ctrl,  exp_ctrl(1));
      chk("b_illegal",  bus_b.illegal,     m_ill[1]);
      chk("b_phase",    bus_b.mem_phase,   m_cnt[1]);
      chk("b_id_ready", bus_b.id_ready,    !m_hold(1));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(bit v, bit [3:0] op, bit b5 = 0, bit b4 = 0, bit fl = 0,
                     bit resp = 0, bit b11 = 0);
    s_valid = v; s_op = op; s_b5 = b5; s_b4 = b4; s_flush = fl; s_resp = resp; s_b11 = b11;
    @(negedge clk);
    #2;
  endtask

  initial begin
    m_clear();
    @(negedge clk);
    #2;
    chk("rst_valid",    bus_a.stage_valid, 0);
    chk("rst_id_ready", bus_a.id_ready,    1);
    run_cmp = 1'b1;
    reset_n = 1'b1;

    // ADD with immediate, no stalls
    cyc(1, op_add, 1);
    chk("add_s0_ctrl", a_ctrl(0), W_ADD_I);
    chk("add_s0_v",    bus_a.stage_valid[0], 1);
    cyc(0, 0);
    cyc(0, 0);
    chk("add_wb_ctrl", a_ctrl(2), W_ADD_I);
    chk("add_wb_v",    bus_a.stage_valid[2], 1);

    // LDR held three cycles in MEM
    cyc(1, op_ldr);
    cyc(1, op_add, 0);
    for (int n = 0; n < 3; n++) begin
      chk("ldr_hold_id_ready", bus_a.id_ready, 0);
      cyc(1, op_and, 1, 0, 0, 0);
    end
    chk("ldr_wb_bubble", bus_a.stage_valid[2], 0);
    chk("ldr_ex_kept",   a_ctrl(0), W_ADD_R);
    chk("ldr_mem_ctrl",  a_ctrl(1), W_LDR);
    cyc(1, op_and, 1, 0, 0, 1);
    chk("ldr_wb_ctrl", a_ctrl(2), W_LDR);
    chk("ldr_wb_v",    bus_a.stage_valid[2], 1);

    // LDI with responses at +1 and +4
    cyc(1, op_ldi);
    cyc(0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("ldi_phase1", bus_a.mem_phase, 1);
    chk("ldi_mem_ctrl", a_ctrl(1), W_LDI);
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("ldi_phase0", bus_a.mem_phase, 0);
    chk("ldi_wb_ctrl", a_ctrl(2), W_LDI);

    // flush while LDI is held
    cyc(1, op_ldi);
    cyc(1, op_add, 1);
    cyc(1, op_and, 0, 0, 1, 0);
    chk("flush_ex_v",  bus_a.stage_valid[0], 0);
    chk("flush_mem_v", bus_a.stage_valid[1], 1);
    chk("flush_mem_ctrl", a_ctrl(1), W_LDI);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("flush_ldi_wb", a_ctrl(2), W_LDI);
    cyc(0, 0, 0, 0, 0, 1);
    chk("stray_resp_phase", bus_a.mem_phase, 0);
    cyc(1, op_add, 1);
    cyc(1, op_and, 1, 0, 1, 0);
    chk("flush_free_mem", a_ctrl(1), W_ADD_I);

    // RTI
    cyc(1, op_rti);
    chk("rti_a_illegal", bus_a.illegal, 1);
    chk("rti_a_s0_v",    bus_a.stage_valid[0], 0);
    chk("rti_b_illegal", bus_b.illegal, 1);
    chk("rti_b_s0_v",    bus_b.stage_valid[0], 1);
    chk("rti_b_s0_ctrl", b_ctrl(0), 0);
    cyc(0, 0);
    chk("rti_pulse_end", bus_a.illegal, 0);
    cyc(1, op_rti, 0, 0, 1, 0);
    chk("rti_flush_no_ill", bus_a.illegal, 0);

    // SHF arithmetic right
    cyc(1, op_shf, 1, 1);
    chk("shf_sra_ctrl", a_ctrl(0), W_SRA);

    // sweep every opcode and operand-bit pattern with varying response timing
    for (int op = 0; op < 16; op++) begin
      for (int p = 0; p < 4; p++) begin
        cyc(1, 4'(op), p[0], p[1], (op + p) % 7 == 3, (op + p) % 3 != 0, p[1]);
      end
    end
    for (int n = 0; n < 4; n++) cyc(0, 0, 0, 0, 0, 1);

    // reset mid-stream with three ops in flight
    cyc(1, op_add, 1);
    cyc(1, op_ldr);
    cyc(1, op_and, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_a_valid", bus_a.stage_valid, 0);
    chk("mid_rst_a_ctrl",  bus_a.stage_ctrl,  0);
    chk("mid_rst_a_rdy",   bus_a.id_ready,    1);
    chk("mid_rst_a_phase", bus_a.mem_phase,   0);
    chk("mid_rst_b_valid", bus_b.stage_valid, 0);
    chk("mid_rst_b_ctrl",  bus_b.stage_ctrl,  0);
    cyc(1, op_add);
    cyc(0, 0);
    reset_n = 1'b1;
    cyc(1, op_ldb);
    cyc(0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0);

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Parametrised successor to the LC-3b combinational control decoder.
- Decodes the ID-stage opcode into an lc3b_control_word, then carries it through NSTAGE registered stages (EX, MEM, …, WB), each with its own valid bit.
- Generates the pipeline hold for multi-access memory ops (one access for LDB/LDR/STB/STR; two for LDI/STI), inserts bubbles, and supports flush of stages younger than MEM.
- Sits between fetch/decode and the datapath stage registers.

Parameters:
- NSTAGE, 3, number of control stages after ID (index 0 = EX, index NSTAGE-1 = WB); minimum 3.
- MEM_IDX, 1, stage index of the memory stage; constraint 0 < MEM_IDX < NSTAGE-1.
- CW_W, $bits(lc3b_control_word), width of one packed control word.
- TRAP_ON_ILLEGAL, 1, 1 = illegal opcode raises illegal and enters as a bubble; 0 = enters valid with an all-zero word.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_valid  in  1  ID holds a valid instruction.
- opcode  in  4  lc3b_opcode of the ID instruction.
- bit11  in  1  IR[11].
- bit5  in  1  IR[5].
- bit4  in  1  IR[4].
- id_ready  out  1  combinational; ID instruction is captured at this edge.
- flush  in  1  kill stages 0..MEM_IDX-1 and the ID instruction at this edge.
- mem_resp  in  1  memory access completed this cycle.
- mem_phase  out  1  0 = first/only access, 1 = indirect second access (LDI/STI).
- stage_valid  out  NSTAGE  per-stage valid.
- stage_ctrl  out  NSTAGE*CW_W  per-stage control word; stage i occupies bits [i*CW_W +: CW_W].
- illegal  out  1  one-cycle registered pulse.

Behaviour:
- Reset (async assert, sync release): stage_valid=0, stage_ctrl=0, mem_cnt=0, mem_phase=0, illegal=0. id_ready=1 during and after reset.
- Decode mapping is the team LC-3b control table, unchanged:
  - ADD/AND: b1_mux_sel=bit5.
  - SHF aluop: alu_sll if bit4=0; otherwise alu_srl if bit5=0, alu_sra if bit5=1.
  - ctrl.opcode=opcode.
  - RTI (the only table default) is illegal.
- memop = stage MEM valid and its opcode ∈ {LDB, LDR, LDI, STB, STR, STI}.
- need = 2 if ldi_sti=1, else 1.
- done = mem_resp && (mem_cnt+1 == need).
- hold = memop && !done.
- id_ready = !hold.
- Edge update, priority order: reset > flush > hold > advance.
  - Stages above MEM_IDX always shift up by one; WB retires.
  - Stage MEM_IDX+1 receives MEM's word when !hold. When hold, it receives a bubble: valid=0, ctrl=0.
  - When hold, stages 0..MEM_IDX keep their contents, and the ID instruction is not captured.
  - When !hold, stages 1..MEM_IDX take from the previous stage. Stage 0 takes the decoded word with valid = if_valid && !(illegal_op && TRAP_ON_ILLEGAL).
  - When flush: stages 0..MEM_IDX-1 become valid=0, ctrl=0. The ID instruction is dropped and illegal is not raised. MEM and older stages follow the normal rules, so a held MEM op keeps holding.
- mem_cnt (1 bit):
  - Increments on mem_resp when memop && !done.
  - Clears when MEM advances.
  - mem_resp with !memop is ignored.
  - mem_phase = mem_cnt.
- illegal = 1 for one cycle after an edge where an RTI was captured (if_valid && id_ready && !flush), regardless of TRAP_ON_ILLEGAL.
- Zero combinational paths from mem_resp to stage_ctrl. Only id_ready depends combinationally on mem_resp.

Test Plan:
- Reset mid-stream with 3 ops in flight → all stage_valid=0 and all stage_ctrl=0 immediately, asynchronously; id_ready=1.
- ADD with bit5=1, no stalls → appears in stage 0 one edge after capture, in WB after 3 edges, with b1_mux_sel=1, aluop=alu_add, reg_load=1, load_cc=1.
- LDR reaches MEM, mem_resp delayed 3 cycles → id_ready=0 for those 3 cycles; EX keeps the following ADD; WB receives 3 bubbles; LDR reaches WB one edge after mem_resp.
- LDI in MEM, mem_resp at cycles +1 and +4 → mem_phase 0 then 1 after the first response; held until the second response; mem_cnt=0 after it advances.
- flush while LDI is held in MEM → EX valid=0 next edge; LDI continues and completes normally.
- RTI captured with TRAP_ON_ILLEGAL=1 → illegal=1 for exactly one cycle; stage 0 valid=0. With TRAP_ON_ILLEGAL=0 → stage 0 valid=1, ctrl=0.
